// File: rtl/digit_serial_adder_nb_if.sv
// Handshake and operand/result bundle for digit_serial_adder_nb.
// The slave modport is the adder's view; master is the operand source and result consumer.
interface digit_serial_adder_nb_if #(
   parameter int N = 16
);
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] i_op_a;
   logic [N-1:0] i_op_b;
   logic         i_carry_in;
   logic         i_sub;
   logic         o_valid;
   logic         i_ready;
   logic [N-1:0] o_sum;
   logic         o_carry_out;
   logic         o_overflow;
   logic         o_zero;

   modport slave (
      input  i_valid, i_op_a, i_op_b, i_carry_in, i_sub, i_ready,
      output o_ready, o_valid, o_sum, o_carry_out, o_overflow, o_zero
   );

   modport master (
      output i_valid, i_op_a, i_op_b, i_carry_in, i_sub, i_ready,
      input  o_ready, o_valid, o_sum, o_carry_out, o_overflow, o_zero
   );
endinterface

// File: rtl/digit_serial_adder_nb.sv
// Multi-cycle N-bit adder/subtractor that processes one D-bit digit per cycle through a
// registered carry, with valid/ready handshakes and carry/overflow/zero flags.
module digit_serial_adder_nb #(
   parameter int N = 16,
   parameter int D = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   digit_serial_adder_nb_if.slave bus
);
   localparam int K  = N / D;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   work_q, work_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   sum_q, sum_d;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;
   logic           zero_q, zero_d;

   logic [D-1:0]   a_dig_s;
   logic [D-1:0]   b_dig_s;
   logic [D:0]     dig_sum_s;
   logic           msb_cin_s;
   logic           ready_s;
   logic           valid_s;

   assign a_dig_s   = a_q[cnt_q*D +: D];
   assign b_dig_s   = b_q[cnt_q*D +: D];
   assign dig_sum_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{D{1'b0}}, carry_q};
   // Carry into the sign bit, recovered from the sum bit of the top digit.
   assign msb_cin_s = a_dig_s[D-1] ^ b_dig_s[D-1] ^ dig_sum_s[D-1];

   // State and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         a_q     <= {N{1'b0}};
         b_q     <= {N{1'b0}};
         work_q  <= {N{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         sum_q   <= {N{1'b0}};
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               state_d = RUN;
               a_d     = bus.i_op_a;
               b_d     = bus.i_sub ? ~bus.i_op_b : bus.i_op_b;
               carry_d = bus.i_sub ? 1'b1 : bus.i_carry_in;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            work_d[cnt_q*D +: D] = dig_sum_s[D-1:0];
            carry_d              = dig_sum_s[D];
            if (cnt_q == CW'(K - 1)) begin
               state_d = DONE;
               cnt_d   = {CW{1'b0}};
               sum_d   = work_d;
               cout_d  = dig_sum_s[D];
               ovf_d   = msb_cin_s ^ dig_sum_s[D];
               zero_d  = (work_d == {N{1'b0}});
            end else begin
               state_d = RUN;
               cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            if (bus.i_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the registered state only.
   always_comb begin
      ready_s = 1'b0;
      valid_s = 1'b0;
      case (state_q)
         IDLE:    ready_s = 1'b1;
         RUN:     ready_s = 1'b0;
         DONE:    valid_s = 1'b1;
         default: ready_s = 1'b0;
      endcase
   end

   assign bus.o_ready     = ready_s;
   assign bus.o_valid     = valid_s;
   assign bus.o_sum       = sum_q;
   assign bus.o_carry_out = cout_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_zero      = zero_q;
endmodule

// File: tb/tb_digit_serial_adder_nb.sv
// Directed bench for digit_serial_adder_nb: three instances (D=4, 16, 1) share the same
// stimulus; each result, flag set and latency is compared with hand-computed values.
module tb_digit_serial_adder_nb;
   logic        clk;
   logic        rst;
   logic        valid;
   logic        rdy;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        cin;
   logic        sub;

   int errors;
   int checks;

   logic [15:0] res_sum [3];
   logic        res_c   [3];
   logic        res_v   [3];
   logic        res_z   [3];
   int          lat     [3];
   int          exp_lat [3];

   digit_serial_adder_nb_if #(.N(16)) if4 ();
   digit_serial_adder_nb_if #(.N(16)) if16 ();
   digit_serial_adder_nb_if #(.N(16)) if1 ();

   assign if4.i_valid     = valid;
   assign if4.i_ready     = rdy;
   assign if4.i_op_a      = op_a;
   assign if4.i_op_b      = op_b;
   assign if4.i_carry_in  = cin;
   assign if4.i_sub       = sub;
   assign if16.i_valid    = valid;
   assign if16.i_ready    = rdy;
   assign if16.i_op_a     = op_a;
   assign if16.i_op_b     = op_b;
   assign if16.i_carry_in = cin;
   assign if16.i_sub      = sub;
   assign if1.i_valid     = valid;
   assign if1.i_ready     = rdy;
   assign if1.i_op_a      = op_a;
   assign if1.i_op_b      = op_b;
   assign if1.i_carry_in  = cin;
   assign if1.i_sub       = sub;

   digit_serial_adder_nb #(.N(16), .D(4))  dut4  (.i_clk(clk), .i_rst(rst), .bus(if4));
   digit_serial_adder_nb #(.N(16), .D(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(if16));
   digit_serial_adder_nb #(.N(16), .D(1))  dut1  (.i_clk(clk), .i_rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present an operation at a falling edge, let the next rising edge accept it.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      cin   = c;
      sub   = s;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Called at the falling edge after the accept edge; records each instance's first result.
   task automatic collect();
      for (int i = 0; i < 3; i++) lat[i] = 0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j == 1) chk("ready_low_in_run", {31'd0, if4.o_ready}, 32'd0);
         if (lat[0] == 0 && if4.o_valid) begin
            lat[0] = j; res_sum[0] = if4.o_sum; res_c[0] = if4.o_carry_out;
            res_v[0] = if4.o_overflow; res_z[0] = if4.o_zero;
         end
         if (lat[1] == 0 && if16.o_valid) begin
            lat[1] = j; res_sum[1] = if16.o_sum; res_c[1] = if16.o_carry_out;
            res_v[1] = if16.o_overflow; res_z[1] = if16.o_zero;
         end
         if (lat[2] == 0 && if1.o_valid) begin
            lat[2] = j; res_sum[2] = if1.o_sum; res_c[2] = if1.o_carry_out;
            res_v[2] = if1.o_overflow; res_z[2] = if1.o_zero;
         end
         if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      end
   endtask

   task automatic check_op(input string tag, input logic [15:0] s, input logic c,
                           input logic v, input logic z);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_sum_%0d", tag, i),  {16'd0, res_sum[i]}, {16'd0, s});
         chk($sformatf("%s_cout_%0d", tag, i), {31'd0, res_c[i]},   {31'd0, c});
         chk($sformatf("%s_ovf_%0d", tag, i),  {31'd0, res_v[i]},   {31'd0, v});
         chk($sformatf("%s_zero_%0d", tag, i), {31'd0, res_z[i]},   {31'd0, z});
         chk($sformatf("%s_lat_%0d", tag, i),  lat[i],              exp_lat[i]);
      end
   endtask

   // One-cycle output handshake for all instances, all of which sit in DONE by now.
   task automatic release_result();
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      chk("ready_after_hs",  {31'd0, if4.o_ready}, 32'd1);
      chk("valid_after_hs",  {31'd0, if4.o_valid}, 32'd0);
      chk("ready16_after_hs", {31'd0, if16.o_ready}, 32'd1);
      chk("ready1_after_hs",  {31'd0, if1.o_ready}, 32'd1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_lat[0] = 4;
      exp_lat[1] = 1;
      exp_lat[2] = 16;
      rst   = 1'b1;
      valid = 1'b0;
      rdy   = 1'b0;
      op_a  = 16'h0000;
      op_b  = 16'h0000;
      cin   = 1'b0;
      sub   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {31'd0, if4.o_ready},     32'd1);
      chk("rst_valid", {31'd0, if4.o_valid},     32'd0);
      chk("rst_sum",   {16'd0, if4.o_sum},       32'd0);
      chk("rst_cout",  {31'd0, if4.o_carry_out}, 32'd0);
      chk("rst_ovf",   {31'd0, if4.o_overflow},  32'd0);
      chk("rst_zero",  {31'd0, if4.o_zero},      32'd0);

      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      collect();
      check_op("add", 16'h5555, 1'b0, 1'b0, 1'b0);

      // Backpressure: stay in DONE while new operands wave around on the inputs.
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1;
         op_a  = 16'h1111 * (16'd1 + 16'(i));
         op_b  = 16'hF0F0 ^ 16'(i);
         @(negedge clk);
         chk("bp_valid", {31'd0, if4.o_valid}, 32'd1);
         chk("bp_ready", {31'd0, if4.o_ready}, 32'd0);
         chk("bp_sum",   {16'd0, if4.o_sum},   32'h5555);
      end
      op_a = 16'h0003;
      op_b = 16'h0004;
      cin  = 1'b0;
      sub  = 1'b0;
      rdy  = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      chk("hs_not_accepted_ready", {31'd0, if4.o_ready}, 32'd1);
      chk("hs_not_accepted_valid", {31'd0, if4.o_valid}, 32'd0);
      chk("idle_holds_sum",        {16'd0, if4.o_sum},   32'h5555);
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      collect();
      check_op("bp_new", 16'h0007, 1'b0, 1'b0, 1'b0);
      release_result();

      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      collect();
      check_op("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
      release_result();

      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      collect();
      check_op("sovf", 16'h8000, 1'b0, 1'b1, 1'b0);
      release_result();

      issue(16'h0001, 16'h0002, 1'b1, 1'b0);
      collect();
      check_op("add_cin", 16'h0004, 1'b0, 1'b0, 1'b0);
      release_result();

      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      collect();
      check_op("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      release_result();

      issue(16'h8000, 16'h0001, 1'b0, 1'b1);
      collect();
      check_op("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
      release_result();

      // Reset in the middle of RUN on the D=4 instance (digit 2 pending).
      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_run_ready", {31'd0, if4.o_ready}, 32'd0);
      chk("mid_run_valid", {31'd0, if4.o_valid}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("runrst_ready", {31'd0, if4.o_ready}, 32'd1);
      chk("runrst_valid", {31'd0, if4.o_valid}, 32'd0);
      chk("runrst_sum",   {16'd0, if4.o_sum},   32'd0);
      chk("runrst_cout",  {31'd0, if4.o_carry_out}, 32'd0);
      chk("runrst_ovf",   {31'd0, if4.o_overflow},  32'd0);
      chk("runrst_valid16", {31'd0, if16.o_valid}, 32'd0);
      repeat (5) @(negedge clk);
      chk("runrst_no_result", {31'd0, if4.o_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
